btn_debounce_pulse: RTL
=======================

Name: btn_debounce_pulse

Overview:
Upstream conditioning stage for the 4-bit T-flip-flop counter. It synchronises a raw, bouncy push-button and debounces it. Each debounced press produces exactly one single-cycle pulse, suitable for driving the counter's toggle-enable input `t`. Optional auto-repeat emits further pulses while the button stays held.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; must be >= 2.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a press or release; must be >= 1.
- REPEAT_EN, 0, 1 enables auto-repeat while held.
- REPEAT_DELAY, 50000000, cycles in HELD before the first repeat pulse; must be >= 1.
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses; must be >= 1.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- btn_in, input, 1, raw button level, asynchronous to clk.
- pulse_out, output, 1, one-cycle pulse per accepted press and per repeat; connects to the counter's `t`.
- btn_level, output, 1, debounced button level.
- bouncing, output, 1, high while in DB_PRESS or DB_RELEASE.

Behaviour:
- Reset (reset=0, asynchronous):
  - synchroniser flops, counters, pulse_out, btn_level and bouncing all clear to 0.
  - FSM goes to IDLE.
  - Reset asserted mid-operation aborts immediately; no pulse is emitted.
- Synchroniser: btn_sync is the output of the SYNC_STAGES flop chain. The FSM uses only btn_sync, never btn_in.
- Debounce counter: width is $clog2(DEBOUNCE_CYCLES+1). It saturates and never wraps.
- Repeat counter: width is $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- FSM states:
  - IDLE (btn_level=0):
    - btn_sync=1 -> DB_PRESS, debounce counter cleared to 0.
  - DB_PRESS:
    - btn_sync=0 -> IDLE; bounce rejected, no pulse.
    - Otherwise the counter increments.
    - On reaching DEBOUNCE_CYCLES-1 -> HELD; pulse_out=1 in the next cycle; btn_level=1; repeat counter cleared.
  - HELD (btn_level=1):
    - btn_sync=0 -> DB_RELEASE, debounce counter cleared.
    - If REPEAT_EN=1: repeat counter runs. The first pulse comes REPEAT_DELAY cycles after entering HELD, then one every REPEAT_PERIOD cycles.
  - DB_RELEASE (btn_level stays 1):
    - btn_sync=1 -> HELD; repeat counter restarts from 0, no pulse.
    - Stable 0 for DEBOUNCE_CYCLES cycles -> IDLE, btn_level=0. A release never generates a pulse.
- Timing:
  - pulse_out, btn_level and bouncing are registered outputs.
  - Latency from raw btn_in rise (held stable) to pulse_out high = SYNC_STAGES + DEBOUNCE_CYCLES cycles.
  - pulse_out is high for exactly 1 cycle per event and is never high in consecutive cycles.
- Boundary conditions:
  - A bounce shorter than DEBOUNCE_CYCLES in either direction is fully rejected.
  - A button held across reset release is treated as a new press: one pulse after the debounce interval.
  - A repeat pulse and a HELD->DB_RELEASE transition in the same cycle: the pulse is emitted and the state still changes.

Decomposition:
- Shared header debounce_defs.vh holds:
  - state encodings (ST_IDLE=2'd0, ST_DB_PRESS=2'd1, ST_HELD=2'd2, ST_DB_RELEASE=2'd3);
  - default timing constants.
- One sub-module, sync_ff:
  - parameterised SYNC_STAGES flop chain with the same asynchronous active-low reset;
  - reusable for the other asynchronous inputs in the lab designs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_EN=0 unless noted.
- Reset: hold reset=0 with btn_in=1 -> pulse_out=0, btn_level=0, bouncing=0. Release reset with btn_in=1 held -> exactly one pulse, 6 cycles after the release edge.
- Clean press: btn_in 0->1 at edge N, held high -> pulse_out=1 only in cycle N+6; btn_level=1 from N+6. Release and hold low -> btn_level=0 6 cycles later; no pulse.
- Bounce rejection: btn_in pattern 1,0,1,1,0,1 toggled every 2 cycles, then steady 0 -> pulse_out never asserts; bouncing toggles; btn_level stays 0.
- Release bounce: with the button held, drop btn_in low for 2 cycles, then back high -> btn_level stays 1; no second pulse.
- Auto-repeat (REPEAT_EN=1, REPEAT_DELAY=8, REPEAT_PERIOD=3): hold btn_in high for 30 cycles -> pulses at cycles 6, 14, 17, 20, 23, 26, 29 relative to the press.
- Counter integration: drive the 4-bit counter's t from pulse_out and apply 17 clean presses -> counter reads 4'b0001 (wrap-around confirmed).

Source files
------------

// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the push-button debounce / pulse stage.
package btn_debounce_pulse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_DB_PRESS   = 2'd1,
      ST_HELD       = 2'd2,
      ST_DB_RELEASE = 2'd3
   } db_state_t;

   // Default timing, sized for a 50 MHz clk_sys-class clock.
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_REPEAT_EN       = 0;
   localparam int DEF_REPEAT_DELAY    = 50000000;
   localparam int DEF_REPEAT_PERIOD   = 10000000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce_pulse_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level input.
// Reusable for any other asynchronous input that needs bringing into clk.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the raw level through the flop chain; only the last stage is used.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronise, debounce, and emit one clk-wide
// pulse per accepted press (plus optional auto-repeat while held).
//
// state         | meaning
// --------------+-------------------------------------------------------
// ST_IDLE       | button released and stable, btn_level = 0
// ST_DB_PRESS   | button seen high, counting stable-high samples
// ST_HELD       | press accepted, btn_level = 1, repeat timer running
// ST_DB_RELEASE | button seen low while held, counting stable-low samples
module btn_debounce_pulse
   import btn_debounce_pulse_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_EN       = DEF_REPEAT_EN,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic pulse_out,
   output logic btn_level,
   output logic bouncing
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   // The sample that moves the FSM into a debounce state counts as the
   // first stable sample, so acceptance happens when the incremented
   // count reaches DEBOUNCE_CYCLES-1.
   localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
   localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);
   localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

   db_state_t        state;
   logic             btn_sync;
   logic [DB_W-1:0]  db_cnt;
   logic [DB_W-1:0]  db_inc;
   logic [RPT_W-1:0] rpt_cnt;
   logic [RPT_W-1:0] rpt_tgt;
   logic             rpt_first;
   logic             rpt_hit;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_in),
      .q     (btn_sync)
   );

   // Saturating debounce increment and repeat-timer terminal compare.
   always_comb begin
      db_inc = db_cnt;
      if (db_cnt != DB_LAST) begin
         db_inc = db_cnt + DB_ONE;
      end
      rpt_tgt = rpt_first ? RPT_FIRST : RPT_NEXT;
      rpt_hit = (rpt_cnt == rpt_tgt);
   end

   // Debounce FSM with registered pulse, level and bouncing outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         db_cnt    <= '0;
         rpt_cnt   <= '0;
         rpt_first <= 1'b1;
         pulse_out <= 1'b0;
         btn_level <= 1'b0;
         bouncing  <= 1'b0;
      end else begin
         pulse_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (btn_sync) begin
                  db_cnt <= '0;
                  if (DB_LAST == '0) begin
                     state     <= ST_HELD;
                     pulse_out <= 1'b1;
                     btn_level <= 1'b1;
                     rpt_cnt   <= '0;
                     rpt_first <= 1'b1;
                  end else begin
                     state    <= ST_DB_PRESS;
                     bouncing <= 1'b1;
                  end
               end
            end
            ST_DB_PRESS: begin
               if (!btn_sync) begin
                  state    <= ST_IDLE;
                  bouncing <= 1'b0;
               end else if (db_inc == DB_LAST) begin
                  state     <= ST_HELD;
                  pulse_out <= 1'b1;
                  btn_level <= 1'b1;
                  bouncing  <= 1'b0;
                  rpt_cnt   <= '0;
                  rpt_first <= 1'b1;
               end else begin
                  db_cnt <= db_inc;
               end
            end
            ST_HELD: begin
               // Repeat fires independently of a simultaneous release.
               if (REPEAT_EN != 0) begin
                  if (rpt_hit) begin
                     pulse_out <= ~pulse_out;
                     rpt_cnt   <= '0;
                     rpt_first <= 1'b0;
                  end else begin
                     rpt_cnt <= rpt_cnt + RPT_ONE;
                  end
               end
               if (!btn_sync) begin
                  db_cnt <= '0;
                  if (DB_LAST == '0) begin
                     state     <= ST_IDLE;
                     btn_level <= 1'b0;
                  end else begin
                     state    <= ST_DB_RELEASE;
                     bouncing <= 1'b1;
                  end
               end
            end
            ST_DB_RELEASE: begin
               if (btn_sync) begin
                  state     <= ST_HELD;
                  bouncing  <= 1'b0;
                  rpt_cnt   <= '0;
                  rpt_first <= 1'b1;
               end else if (db_inc == DB_LAST) begin
                  state     <= ST_IDLE;
                  btn_level <= 1'b0;
                  bouncing  <= 1'b0;
               end else begin
                  db_cnt <= db_inc;
               end
            end
            default: begin
               state     <= ST_IDLE;
               btn_level <= 1'b0;
               bouncing  <= 1'b0;
            end
         endcase
      end
   end

endmodule
